// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared widths, starvation default and arbiter state encoding
package mips_mem_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STARVE_MAX_DEF = 8;
    typedef enum logic {
        NORMAL    = 1'b0,
        FORCE_DBG = 1'b1
    } arb_state_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: counts consecutive contended cycles and flags the last one before a forced debug slot
module starve_counter #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    logic [7:0] count;
    assign hit = count == 8'(STARVE_MAX - 1);
    // clear wins over increment so the forcing cycle restarts the count
    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc)
            count <= count + 8'd1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the MEM stage and a debug port with anti-starvation
module mem_arbiter import mips_mem_pkg::*; #(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    arb_state_t        state, next_state;
    logic              p_grant, d_grant, inc, clr, hit;
    logic              rd_p, rd_d;
    logic [DATA_W-1:0] p_hold, d_hold;

    assign inc = state == NORMAL && p_req && d_req;
    assign clr = !d_req || d_grant || (inc && hit);
    assign p_rvalid = rd_p;
    assign d_rvalid = rd_d;

    starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .clr   (clr),
        .hit   (hit)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? NORMAL : next_state;
    end

    // the forced debug slot lasts a single cycle
    always_comb begin
        next_state = (state == NORMAL && inc && hit) ? FORCE_DBG : NORMAL;
    end

    // grants, RAM mux and read-data steering; debug is locked out during reset
    always_comb begin
        d_grant  = !reset && d_req && (state == FORCE_DBG || !p_req);
        p_grant  = p_req && !d_grant;
        p_stall  = p_req && !p_grant;
        d_ready  = d_grant;
        ram_we   = !reset && (d_grant ? d_we : p_grant && p_we);
        ram_addr = d_grant ? d_addr : p_addr;
        ram_din  = d_grant ? d_wdata : p_wdata;
        p_rdata  = rd_p ? ram_dout : p_hold;
        d_rdata  = rd_d ? ram_dout : d_hold;
    end

    // owner tags for reads in flight and held copies of the last returned data
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p   <= 1'b0;
            rd_d   <= 1'b0;
            p_hold <= '0;
            d_hold <= '0;
        end else begin
            rd_p   <= p_grant && !p_we;
            rd_d   <= d_grant && !d_we;
            p_hold <= p_rdata;
            d_hold <= d_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, starvation forcing, read routing and reset
module tb_mem_arbiter;
    logic        clk = 0, reset = 1;
    logic        p_req = 0, p_we = 0, d_req = 0, d_we = 0;
    logic [31:0] p_addr = 0, p_wdata = 0, d_addr = 0, d_wdata = 0;
    logic        p_stall, p_rvalid, d_ready, d_rvalid, ram_we;
    logic [31:0] p_rdata, d_rdata, ram_addr, ram_din, ram_dout;
    logic [31:0] mem [0:255];
    int checks = 0, errors = 0;

    mem_arbiter #(.STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_din;
        ram_dout <= mem[ram_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h55;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_lockout d_ready=%b ram_we=%b exp 0 0", d_ready, ram_we);
        end
        tick();
        d_req = 0; d_we = 0;
        tick();
        reset = 0;
        @(negedge clk);
        checks++;
        if ({p_rvalid, d_rvalid, p_stall} !== 3'b000 || p_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state pv=%b dv=%b ps=%b pr=%h dr=%h exp 0 0 0 0 0", p_rvalid, d_rvalid, p_stall, p_rdata, d_rdata);
        end
    endtask

    task automatic test_p_read();
        tick();
        p_req = 1; p_we = 0; p_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (p_stall !== 1'b0 || ram_addr !== 32'h10 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL p_read_grant stall=%b addr=%h we=%b exp 0 10 0", p_stall, ram_addr, ram_we);
        end
        tick();
        p_req = 0;
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL p_read_data pv=%b pr=%h dv=%b exp 1 deadbeef 0", p_rvalid, p_rdata, d_rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b0 || p_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p_read_hold pv=%b pr=%h exp 0 deadbeef", p_rvalid, p_rdata);
        end
    endtask

    task automatic test_d_write_read();
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h20 || ram_din !== 32'h12345678) begin
            errors++;
            $display("FAIL d_write rdy=%b we=%b addr=%h din=%h exp 1 1 20 12345678", d_ready, ram_we, ram_addr, ram_din);
        end
        tick();
        d_we = 0;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1 || d_rvalid !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL d_read_grant rdy=%b dv=%b we=%b exp 1 0 0", d_ready, d_rvalid, ram_we);
        end
        tick();
        d_req = 0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678 || p_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL d_read_data dv=%b dr=%h pv=%b exp 1 12345678 0", d_rvalid, d_rdata, p_rvalid);
        end
    endtask

    task automatic test_starve();
        tick();
        p_req = 1; p_we = 0; p_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h8;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            checks++;
            if (p_stall !== (i % 9 == 0) || d_ready !== (i % 9 == 0)) begin
                errors++;
                $display("FAIL starve_cycle%0d stall=%b rdy=%b exp %b %b", i, p_stall, d_ready, i % 9 == 0, i % 9 == 0);
            end
            tick();
        end
        p_req = 0; d_req = 0;
    endtask

    task automatic test_force_drop();
        tick();
        p_req = 1; d_req = 1;
        for (int j = 1; j <= 18; j++) begin
            d_req = (j != 9);
            @(negedge clk);
            checks++;
            if (p_stall !== (j == 18) || d_ready !== (j == 18)) begin
                errors++;
                $display("FAIL force_drop_cycle%0d stall=%b rdy=%b exp %b %b", j, p_stall, d_ready, j == 18, j == 18);
            end
            tick();
        end
        p_req = 0; d_req = 0;
    endtask

    task automatic test_reset_read();
        tick();
        p_req = 1; p_we = 0; p_addr = 32'h10; reset = 1;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_read_we we=%b rdy=%b exp 0 0", ram_we, d_ready);
        end
        tick();
        reset = 0; p_req = 0;
        @(negedge clk);
        checks++;
        if ({p_rvalid, d_rvalid, p_stall} !== 3'b000 || p_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_read_out pv=%b dv=%b ps=%b pr=%h dr=%h exp 0 0 0 0 0", p_rvalid, d_rvalid, p_stall, p_rdata, d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        p_req = 1; p_we = 0; p_addr = 32'h4;
        tick();
        p_req = 0; d_req = 1; d_we = 0; d_addr = 32'h8;
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b1 || p_rdata !== 32'hA0A00004 || d_rvalid !== 1'b0 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first pv=%b pr=%h dv=%b rdy=%b exp 1 a0a00004 0 1", p_rvalid, p_rdata, d_rvalid, d_ready);
        end
        tick();
        d_req = 0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hB0B00008 || p_rvalid !== 1'b0 || p_rdata !== 32'hA0A00004) begin
            errors++;
            $display("FAIL b2b_second dv=%b dr=%h pv=%b pr=%h exp 1 b0b00008 0 a0a00004", d_rvalid, d_rdata, p_rvalid, p_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || p_rvalid !== 1'b0 || d_rdata !== 32'hB0B00008) begin
            errors++;
            $display("FAIL b2b_idle dv=%b pv=%b dr=%h exp 0 0 b0b00008", d_rvalid, p_rvalid, d_rdata);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        mem[16] = 32'hDEADBEEF;
        mem[4]  = 32'hA0A00004;
        mem[8]  = 32'hB0B00008;
        test_reset();
        test_p_read();
        test_d_write_read();
        test_starve();
        test_force_drop();
        test_reset_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
